// File: rtl/bcd_clock_pkg.sv
// Shared types and constants for the BCD clock mode/set controller.
// Optional feature macro: BCD_CLOCK_CTRL_ALARM_EN adds the alarm-set states.
package bcd_clock_pkg;

  // Controller states; alarm states exist only in the alarm build.
  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SET_HR  = 3'd1,
    S_SET_MIN = 3'd2,
    S_COMMIT  = 3'd3
`ifdef BCD_CLOCK_CTRL_ALARM_EN
    ,
    S_ALM_HR  = 3'd4,
    S_ALM_MIN = 3'd5
`endif
  } state_t;

  // Display blink select encodings.
  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_HR   = 2'd1;
  localparam logic [1:0] EDIT_MIN  = 2'd2;
  localparam logic [1:0] EDIT_ALM  = 2'd3;

  // BCD field limits and reset values.
  localparam logic [7:0] HR_MAX       = 8'h23;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam logic [7:0] SEC_ZERO     = 8'h00;
  localparam logic [7:0] ALARM_HR_RST  = 8'h12;
  localparam logic [7:0] ALARM_MIN_RST = 8'h00;

endpackage

// File: rtl/bcd_clock_ctrl_if.sv
// Front-panel / counter bus of the BCD clock controller.
//   mode_btn, inc_btn : debounced one-cycle button pulses
//   cur_hr, cur_min   : live counter time, BCD
//   cnt_en, load      : counter count enable / parallel-load strobe
//   ld_hr/min/sec     : parallel-load value, BCD
//   edit_sel          : field being edited (blink select)
//   alarm             : alarm indication
interface bcd_clock_ctrl_if;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] cur_hr;
  logic [7:0] cur_min;
  logic       cnt_en;
  logic       load;
  logic [7:0] ld_hr;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;
  logic [1:0] edit_sel;
  logic       alarm;

  // Panel/counter side.
  modport master (
    output mode_btn, inc_btn, cur_hr, cur_min,
    input  cnt_en, load, ld_hr, ld_min, ld_sec, edit_sel, alarm
  );

  // Controller side.
  modport slave (
    input  mode_btn, inc_btn, cur_hr, cur_min,
    output cnt_en, load, ld_hr, ld_min, ld_sec, edit_sel, alarm
  );
endinterface

// File: rtl/bcd_pair_inc.sv
// Combinational two-digit BCD increment with wrap to 00 at max_i.
//   val_i : current BCD value {ms,ls}
//   max_i : value that wraps to 00
//   nxt_o : incremented BCD value
module bcd_pair_inc (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  output logic [7:0] nxt_o
);

  always_comb begin
    nxt_o = 8'h00;
    if (val_i != max_i) begin
      if (val_i[3:0] == 4'd9) nxt_o = {val_i[7:4] + 4'd1, 4'd0};
      else                    nxt_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_clock_ctrl.sv
// Mode/set controller for the hh.mm.ss BCD time counter: tick prescaler,
// button-driven hour/minute set FSM and one-cycle parallel load on commit.
// Ports: clk, reset (sync, active-high), bus (bcd_clock_ctrl_if.slave).
// Optional feature macro: BCD_CLOCK_CTRL_ALARM_EN (alarm registers, arm
// toggle and ALM_HR/ALM_MIN set states); without it alarm is tied 0.
module bcd_clock_ctrl
  import bcd_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  bcd_clock_ctrl_if.slave   bus
);

  localparam int unsigned      PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [7:0]       edit_hr_q, edit_hr_d, edit_min_q, edit_min_d;
  logic [7:0]       ld_hr_q, ld_hr_d, ld_min_q, ld_min_d;
  logic             cnt_en_q, cnt_en_d, load_q, load_d;
  logic [1:0]       edit_sel_q, edit_sel_d;
  logic [7:0]       hr_nxt, min_nxt;

  bcd_pair_inc u_hr_inc  (.val_i(edit_hr_q),  .max_i(HR_MAX),  .nxt_o(hr_nxt));
  bcd_pair_inc u_min_inc (.val_i(edit_min_q), .max_i(MIN_MAX), .nxt_o(min_nxt));

`ifdef BCD_CLOCK_CTRL_ALARM_EN
  logic [7:0] alarm_hr_q, alarm_hr_d, alarm_min_q, alarm_min_d;
  logic [7:0] alm_hr_nxt, alm_min_nxt;
  logic       arm_q, arm_d, alarm_q, alarm_d;

  bcd_pair_inc u_alm_hr_inc  (.val_i(alarm_hr_q),  .max_i(HR_MAX),  .nxt_o(alm_hr_nxt));
  bcd_pair_inc u_alm_min_inc (.val_i(alarm_min_q), .max_i(MIN_MAX), .nxt_o(alm_min_nxt));
`endif

  // Next state, edit registers, prescaler and registered-output values.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    ld_hr_d    = ld_hr_q;
    ld_min_d   = ld_min_q;
    cnt_en_d   = 1'b0;
    load_d     = 1'b0;
    edit_sel_d = EDIT_NONE;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    arm_d       = arm_q;
    alarm_d     = 1'b0;
`endif

    // Mode always beats increment when both arrive together.
    unique case (state_q)
      S_RUN: begin
        if (bus.mode_btn) begin
`ifdef BCD_CLOCK_CTRL_ALARM_EN
          if (arm_q) begin
            state_d = S_ALM_HR;
          end else
`endif
          begin
            state_d    = S_SET_HR;
            edit_hr_d  = bus.cur_hr;
            edit_min_d = bus.cur_min;
          end
        end
`ifdef BCD_CLOCK_CTRL_ALARM_EN
        else if (bus.inc_btn) begin
          arm_d = ~arm_q;
        end
`endif
      end
      S_SET_HR: begin
        if (bus.mode_btn)     state_d   = S_SET_MIN;
        else if (bus.inc_btn) edit_hr_d = hr_nxt;
      end
      S_SET_MIN: begin
        if (bus.mode_btn)     state_d    = S_COMMIT;
        else if (bus.inc_btn) edit_min_d = min_nxt;
      end
      S_COMMIT: state_d = S_RUN;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
      S_ALM_HR: begin
        if (bus.mode_btn)     state_d    = S_ALM_MIN;
        else if (bus.inc_btn) alarm_hr_d = alm_hr_nxt;
      end
      S_ALM_MIN: begin
        if (bus.mode_btn)     state_d     = S_RUN;
        else if (bus.inc_btn) alarm_min_d = alm_min_nxt;
      end
`endif
      default: state_d = S_RUN;
    endcase

    // Prescaler is zero during the load cycle and counts on the edge that
    // leaves COMMIT, so the first tick lands TICK_DIV cycles after load.
    if (state_d == S_COMMIT) begin
      presc_d = '0;
    end else if (state_d == S_RUN && (state_q == S_RUN || state_q == S_COMMIT)) begin
      cnt_en_d = (presc_q == PRE_MAX);
      presc_d  = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_W'(1);
    end

    // Outputs are registered against the next state so they align with it.
    if (state_d == S_COMMIT) begin
      load_d   = 1'b1;
      ld_hr_d  = edit_hr_q;
      ld_min_d = edit_min_q;
    end

    unique case (state_d)
      S_SET_HR:  edit_sel_d = EDIT_HR;
      S_SET_MIN: edit_sel_d = EDIT_MIN;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
      S_ALM_HR, S_ALM_MIN: edit_sel_d = EDIT_ALM;
`endif
      default:   edit_sel_d = EDIT_NONE;
    endcase

`ifdef BCD_CLOCK_CTRL_ALARM_EN
    alarm_d = arm_q && (state_q == S_RUN) &&
              (bus.cur_hr == alarm_hr_q) && (bus.cur_min == alarm_min_q);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      presc_q    <= '0;
      edit_hr_q  <= 8'h00;
      edit_min_q <= 8'h00;
      ld_hr_q    <= 8'h00;
      ld_min_q   <= 8'h00;
      cnt_en_q   <= 1'b0;
      load_q     <= 1'b0;
      edit_sel_q <= EDIT_NONE;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
      alarm_hr_q  <= ALARM_HR_RST;
      alarm_min_q <= ALARM_MIN_RST;
      arm_q       <= 1'b0;
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
      ld_hr_q    <= ld_hr_d;
      ld_min_q   <= ld_min_d;
      cnt_en_q   <= cnt_en_d;
      load_q     <= load_d;
      edit_sel_q <= edit_sel_d;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      arm_q       <= arm_d;
      alarm_q     <= alarm_d;
`endif
    end
  end

  assign bus.cnt_en   = cnt_en_q;
  assign bus.load     = load_q;
  assign bus.ld_hr    = ld_hr_q;
  assign bus.ld_min   = ld_min_q;
  assign bus.ld_sec   = SEC_ZERO;
  assign bus.edit_sel = edit_sel_q;
`ifdef BCD_CLOCK_CTRL_ALARM_EN
  assign bus.alarm    = alarm_q;
`else
  assign bus.alarm    = 1'b0;
`endif

endmodule
